irrigation_scan_ctrl: RTL

Sequential scanner driving the 2-bit selector of the 4:1 sensor multiplexer and consuming its single-bit output. It steps through the four sensor channels and waits a settle time before each sample. Each channel is debounced over consecutive scans. After every full scan it registers the valve command for the irrigation actuator. It is the control stage directly upstream (select) and downstream (data) of the sensor mux.

---
 rtl/irrigation_scan_ctrl_if.sv | 31 +++
 rtl/irrigation_scan_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/irrigation_scan_ctrl_if.sv
// Signal bundle between the irrigation scan controller and its sensor-mux / actuator side.
// master = controller, slave = mux plus actuator environment.
interface irrigation_scan_ctrl_if;
   logic       enable;
   logic       mux_out;
   logic       S1;
   logic       S0;
   logic [3:0] status;
   logic       valve;
   logic       scan_done;

   modport master (
      input  enable,
      input  mux_out,
      output S1,
      output S0,
      output status,
      output valve,
      output scan_done
   );

   modport slave (
      output enable,
      output mux_out,
      input  S1,
      input  S0,
      input  status,
      input  valve,
      input  scan_done
   );
endinterface

// File: rtl/irrigation_scan_ctrl.sv
// Four-channel sensor scanner: drives the mux selector, debounces each channel across scans,
// and registers the valve command once per completed scan.
module irrigation_scan_ctrl #(
   parameter int SETTLE   = 2,
   parameter int DEBOUNCE = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   irrigation_scan_ctrl_if.master bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [2:0] DB_LAST     = 3'(DEBOUNCE - 1);

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] ch_reg;
   logic [3:0] settle_reg;
   logic [3:0] status_w;
   logic       valve_reg;
   logic       settle_run;
   logic       sample_en;
   logic       valve_load;
   logic       done_pulse;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Enable is only consulted at scan boundaries, so a started scan always runs to DONE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (bus.enable) state_next = ST_SETTLE;
         ST_SETTLE: if (settle_reg == SETTLE_LAST) state_next = ST_SAMPLE;
         ST_SAMPLE: state_next = (ch_reg == 2'd3) ? ST_DONE : ST_SETTLE;
         ST_DONE:   state_next = bus.enable ? ST_SETTLE : ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      settle_run = 1'b0;
      sample_en  = 1'b0;
      valve_load = 1'b0;
      done_pulse = 1'b0;
      case (state_reg)
         ST_SETTLE: settle_run = 1'b1;
         ST_SAMPLE: sample_en  = 1'b1;
         ST_DONE: begin
            valve_load = 1'b1;
            done_pulse = 1'b1;
         end
         default: ;
      endcase
   end

   // Settle counter only runs inside SETTLE, so every entry into SETTLE starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settle_reg <= 4'd0;
         ch_reg     <= 2'd0;
         valve_reg  <= 1'b0;
      end else begin
         settle_reg <= settle_run ? settle_reg + 4'd1 : 4'd0;
         if (sample_en) begin
            ch_reg <= ch_reg + 2'd1;
         end
         if (valve_load) begin
            valve_reg <= ~status_w[1] & ((status_w[0] & ~status_w[2]) | status_w[3]);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_deb
         logic [2:0] db_reg;
         logic       lvl_reg;
         logic       hit;

         assign hit = sample_en && (ch_reg == 2'(gi));

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               db_reg  <= 3'd0;
               lvl_reg <= 1'b0;
            end else if (hit) begin
               if (bus.mux_out == lvl_reg) begin
                  db_reg <= 3'd0;
               end else if (db_reg == DB_LAST) begin
                  lvl_reg <= bus.mux_out;
                  db_reg  <= 3'd0;
               end else begin
                  db_reg <= db_reg + 3'd1;
               end
            end
         end

         assign status_w[gi] = lvl_reg;
      end
   endgenerate

   assign bus.S1        = ch_reg[1];
   assign bus.S0        = ch_reg[0];
   assign bus.status    = status_w;
   assign bus.valve     = valve_reg;
   assign bus.scan_done = done_pulse;
endmodule
